// File: rtl/fc_pkg.sv
// Shared fixed-point helpers and FSM/write-select codes for the FC engines.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fc_pkg;

  typedef logic [2:0] fc_state_t;

  localparam fc_state_t ST_IDLE   = 3'd0;
  localparam fc_state_t ST_MAC    = 3'd1;
  localparam fc_state_t ST_STREAM = 3'd2;
  localparam fc_state_t ST_DONE   = 3'd3;
  localparam fc_state_t ST_UPDATE = 3'd4;

  localparam logic [1:0] SEL_ACT = 2'd0;
  localparam logic [1:0] SEL_WGT = 2'd1;
  localparam logic [1:0] SEL_ERR = 2'd2;

  // Wide signed working type: holds a full product of two 32-bit operands.
  typedef logic signed [63:0] fx_wide_t;

  // Clamp v into the signed range of a w-bit word.
  function automatic fx_wide_t fx_sat(input fx_wide_t v, input int w);
    fx_wide_t hi;
    fx_wide_t lo;
    hi = (fx_wide_t'(1) <<< (w - 1)) - fx_wide_t'(1);
    lo = -(fx_wide_t'(1) <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Fixed-point multiply: full-width product, arithmetic rescale, clamp to w bits.
  function automatic fx_wide_t fx_mul(input fx_wide_t a, input fx_wide_t b,
                                      input int frac, input int w);
    return fx_sat((a * b) >>> frac, w);
  endfunction

endpackage

// File: rtl/fc_fixed_mac.sv
// Combinational fixed-point MAC: sum = sat_ACC_W(acc + sat_DW((a*b)>>>FRAC)).
// Latency: 0 cycles (pure combinational).
// Backpressure: none; ports a,b (DW), acc (ACC_W) in; sum (ACC_W) out.
module fc_fixed_mac
  import fc_pkg::*;
#(
  parameter int DW    = 16,
  parameter int FRAC  = 10,
  parameter int ACC_W = 16
) (
  input  logic signed [DW-1:0]    a,
  input  logic signed [DW-1:0]    b,
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [ACC_W-1:0] sum
);

  always_comb begin
    sum = ACC_W'(fx_sat(fx_wide_t'(acc) +
                        fx_mul(fx_wide_t'(a), fx_wide_t'(b), FRAC, DW), ACC_W));
  end

endmodule

// File: rtl/fc_bprop_engine.sv
// Fully-connected backprop engine: error propagation, delta accumulation, batched weight update.
// Latency: start in cycle 0 -> err stream from cycle OUT*IN+1, done in cycle OUT*IN+IN+1.
// Backpressure: none; start/wr_en ignored while busy, batch_end latched as pending.
// Ports: wr_* load A/W/E in IDLE; rd_addr/rd_data registered weight readback;
//        start/busy/done pass control; err_* propagated-error stream;
//        batch_end/update_done weight update. Macro FC_AUTO_BATCH_EN: auto update
//        once BATCH_SIZE samples have been seen.
module fc_bprop_engine
  import fc_pkg::*;
#(
  parameter int IN_CELL    = 32,
  parameter int OUT_CELL   = 20,
  parameter int DW         = 16,
  parameter int FRAC       = 10,
  parameter int LN_SHIFT   = 5,
  parameter int BATCH_SIZE = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [1:0]    wr_sel,
  input  logic [15:0]   wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [15:0]   rd_addr,
  output logic [DW-1:0] rd_data,
  input  logic          start,
  output logic          busy,
  output logic          err_valid,
  output logic [15:0]   err_addr,
  output logic [DW-1:0] err_data,
  output logic          done,
  input  logic          batch_end,
  output logic          update_done
);

  localparam int N_W = OUT_CELL * IN_CELL;
  localparam int DAW = DW + 8;
  localparam int JW  = (IN_CELL  > 1) ? $clog2(IN_CELL)  : 1;
  localparam int IW  = (OUT_CELL > 1) ? $clog2(OUT_CELL) : 1;
  localparam int KW  = (N_W      > 1) ? $clog2(N_W)      : 1;
  localparam logic [JW-1:0] J_LAST     = JW'(IN_CELL - 1);
  localparam logic [KW-1:0] K_LAST     = KW'(N_W - 1);
  localparam logic [15:0]   SAMPLE_MAX = 16'(BATCH_SIZE);

  logic signed [DW-1:0]  a_mem [IN_CELL];
  logic signed [DW-1:0]  e_mem [OUT_CELL];
  logic signed [DW-1:0]  p_mem [IN_CELL];
  logic signed [DW-1:0]  w_mem [N_W];
  logic signed [DAW-1:0] d_mem [N_W];

  fc_state_t      state;
  logic           pending;
  logic [15:0]    samples;
  logic [15:0]    samples_nxt;
  logic           auto_upd;
  logic [JW-1:0]  cnt_j;
  logic [IW-1:0]  cnt_i;
  logic [KW-1:0]  cnt_k;

  logic signed [DW-1:0]  p_sum;
  logic signed [DAW-1:0] d_sum;
  logic signed [DW-1:0]  w_upd;
  logic [DW-1:0]         rd_word;

  // Error propagation: P[j] += W[i][j] * E[i]
  fc_fixed_mac #(.DW(DW), .FRAC(FRAC), .ACC_W(DW)) u_p_mac (
    .a(w_mem[cnt_k]), .b(e_mem[cnt_i]), .acc(p_mem[cnt_j]), .sum(p_sum)
  );

  // Gradient accumulation: D[i][j] += A[j] * E[i]
  fc_fixed_mac #(.DW(DW), .FRAC(FRAC), .ACC_W(DAW)) u_d_mac (
    .a(a_mem[cnt_j]), .b(e_mem[cnt_i]), .acc(d_mem[cnt_k]), .sum(d_sum)
  );

  always_comb begin
    w_upd = DW'(fx_sat(fx_wide_t'(w_mem[cnt_k]) +
                       (fx_wide_t'(d_mem[cnt_k]) >>> LN_SHIFT), DW));
  end

  always_comb begin
    samples_nxt = (samples >= SAMPLE_MAX) ? SAMPLE_MAX : samples + 16'd1;
`ifdef FC_AUTO_BATCH_EN
    auto_upd = (samples_nxt >= SAMPLE_MAX);
`else
    auto_upd = 1'b0;
`endif
  end

  // Readback forwards a weight being written this cycle so rd_data shows the new value.
  always_comb begin
    rd_word = '0;
    if (rd_addr < 16'(N_W)) begin
      rd_word = w_mem[rd_addr[KW-1:0]];
      if (state == ST_UPDATE && rd_addr[KW-1:0] == cnt_k)
        rd_word = w_upd;
      else if (state == ST_IDLE && wr_en && wr_sel == SEL_WGT && wr_addr == rd_addr)
        rd_word = wr_data;
    end
  end

  assign busy        = (state != ST_IDLE);
  assign done        = (state == ST_DONE);
  assign err_valid   = (state == ST_STREAM);
  assign err_addr    = (state == ST_STREAM) ? 16'(cnt_j) : 16'd0;
  assign err_data    = (state == ST_STREAM) ? p_mem[cnt_j] : '0;
  assign update_done = (state == ST_UPDATE) && (cnt_k == K_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      pending <= 1'b0;
      samples <= '0;
      cnt_i   <= '0;
      cnt_j   <= '0;
      cnt_k   <= '0;
      rd_data <= '0;
      for (int j = 0; j < IN_CELL; j++) begin
        a_mem[j] <= '0;
        p_mem[j] <= '0;
      end
      for (int i = 0; i < OUT_CELL; i++) e_mem[i] <= '0;
      for (int k = 0; k < N_W; k++) begin
        w_mem[k] <= DW'(fx_sat(fx_wide_t'(-250 + 3 * k), DW));
        d_mem[k] <= '0;
      end
    end else begin
      rd_data <= rd_word;
      case (state)
        ST_IDLE: begin
          if (wr_en) begin
            if (wr_sel == SEL_ACT && wr_addr < 16'(IN_CELL))  a_mem[wr_addr[JW-1:0]] <= wr_data;
            if (wr_sel == SEL_WGT && wr_addr < 16'(N_W))      w_mem[wr_addr[KW-1:0]] <= wr_data;
            if (wr_sel == SEL_ERR && wr_addr < 16'(OUT_CELL)) e_mem[wr_addr[IW-1:0]] <= wr_data;
          end
          cnt_i <= '0;
          cnt_j <= '0;
          cnt_k <= '0;
          if (start) begin
            // A simultaneous batch_end waits until this pass has finished.
            state   <= ST_MAC;
            pending <= pending | batch_end;
            for (int j = 0; j < IN_CELL; j++) p_mem[j] <= '0;
          end else if (batch_end || pending) begin
            state   <= ST_UPDATE;
            pending <= 1'b0;
          end
        end
        ST_MAC: begin
          p_mem[cnt_j] <= p_sum;
          d_mem[cnt_k] <= d_sum;
          pending      <= pending | batch_end;
          if (cnt_k == K_LAST) begin
            state <= ST_STREAM;
            cnt_i <= '0;
            cnt_j <= '0;
            cnt_k <= '0;
          end else begin
            cnt_k <= cnt_k + KW'(1);
            if (cnt_j == J_LAST) begin
              cnt_j <= '0;
              cnt_i <= cnt_i + IW'(1);
            end else begin
              cnt_j <= cnt_j + JW'(1);
            end
          end
        end
        ST_STREAM: begin
          pending <= pending | batch_end;
          if (cnt_j == J_LAST) begin
            state <= ST_DONE;
            cnt_j <= '0;
          end else begin
            cnt_j <= cnt_j + JW'(1);
          end
        end
        ST_DONE: begin
          samples <= samples_nxt;
          cnt_i   <= '0;
          cnt_j   <= '0;
          cnt_k   <= '0;
          if (pending || batch_end || auto_upd) begin
            state   <= ST_UPDATE;
            pending <= 1'b0;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_UPDATE: begin
          w_mem[cnt_k] <= w_upd;
          d_mem[cnt_k] <= '0;
          pending      <= pending | batch_end;
          if (cnt_k == K_LAST) begin
            state   <= ST_IDLE;
            samples <= '0;
            cnt_k   <= '0;
          end else begin
            cnt_k <= cnt_k + KW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_bprop_engine.sv
module tb_fc_bprop_engine;

  localparam int IN    = 2;
  localparam int OUT   = 2;
  localparam int N     = IN * OUT;
  localparam int BATCH = 2;
`ifdef FC_AUTO_BATCH_EN
  localparam int AUTO = 1;
`else
  localparam int AUTO = 0;
`endif

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               wr_en = 1'b0;
  logic [1:0]         wr_sel = 2'd0;
  logic [15:0]        wr_addr = 16'd0;
  logic [15:0]        wr_data = 16'd0;
  logic [15:0]        rd_addr = 16'd0;
  logic signed [15:0] rd_data;
  logic               start = 1'b0;
  logic               busy;
  logic               err_valid;
  logic [15:0]        err_addr;
  logic signed [15:0] err_data;
  logic               done;
  logic               batch_end = 1'b0;
  logic               update_done;

  fc_bprop_engine #(
    .IN_CELL(IN), .OUT_CELL(OUT), .DW(16), .FRAC(10), .LN_SHIFT(5), .BATCH_SIZE(BATCH)
  ) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .start(start), .busy(busy),
    .err_valid(err_valid), .err_addr(err_addr), .err_data(err_data),
    .done(done), .batch_end(batch_end), .update_done(update_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int errors = 0;
  int checks = 0;

  // Reference model state
  int mw[N];
  int md[N];
  int ma[IN];
  int me[OUT];
  int samples_m;
  int last_p[IN];
  int last_pulses;

  typedef struct {
    int sel;
    int addr;
    int data;
    int rd;
    int exp;
  } wr_vec_t;

  wr_vec_t vecs[8];

  function automatic int sat(input longint v, input int w);
    longint hi;
    longint lo;
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -(longint'(1) << (w - 1));
    if (v > hi) return int'(hi);
    if (v < lo) return int'(lo);
    return int'(v);
  endfunction

  function automatic int fmul(input int a, input int b);
    return sat((longint'(a) * longint'(b)) >>> 10, 16);
  endfunction

  function automatic int rnd(input bit big);
    if (big) return int'($urandom_range(0, 65535)) - 32768;
    return int'($urandom_range(0, 4095)) - 2048;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      mw[k] = sat(-250 + 3 * k, 16);
      md[k] = 0;
    end
    for (int j = 0; j < IN; j++) ma[j] = 0;
    for (int i = 0; i < OUT; i++) me[i] = 0;
    samples_m = 0;
  endtask

  task automatic model_update();
    for (int k = 0; k < N; k++) begin
      mw[k] = sat(longint'(mw[k]) + (longint'(md[k]) >>> 5), 16);
      md[k] = 0;
    end
    samples_m = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    check("rst_busy", busy, 0);
    check("rst_err_valid", err_valid, 0);
    check("rst_done", done, 0);
    check("rst_update_done", update_done, 0);
    check("rst_rd_data", rd_data, 0);
    tick();
    reset = 1'b0;
    model_reset();
  endtask

  task automatic write(input int sel, input int addr, input int data);
    logic signed [15:0] d;
    d = 16'(data);
    wr_en = 1'b1; wr_sel = 2'(sel); wr_addr = 16'(addr); wr_data = d;
    tick();
    wr_en = 1'b0;
    if (sel == 0 && addr < IN)  ma[addr] = int'(d);
    if (sel == 1 && addr < N)   mw[addr] = int'(d);
    if (sel == 2 && addr < OUT) me[addr] = int'(d);
  endtask

  task automatic read_w(input int k, output int v);
    rd_addr = 16'(k);
    tick();
    v = int'(rd_data);
  endtask

  task automatic check_w_all();
    int v;
    for (int k = 0; k < N; k++) begin
      read_w(k, v);
      check("w_readback", v, mw[k]);
    end
  endtask

  // Called in the first cycle after done (or after a batch_end request was taken).
  task automatic wait_update(input int exp_pulses);
    int pulses = 0;
    int n = 0;
    int quiet_bad = 0;
    while (busy && n < 2 * N + 8) begin
      if (update_done) pulses++;
      tick();
      n++;
    end
    check("upd_terminates", busy, 0);
    check("upd_pulses", pulses, exp_pulses);
    for (int c = 0; c < 4; c++) begin
      tick();
      if (busy || update_done || done) quiet_bad++;
    end
    check("idle_quiet", quiet_bad, 0);
    last_pulses = pulses;
    if (exp_pulses != 0) model_update();
  endtask

  // One backprop pass; be_at = cycle index of a batch_end pulse (-1: none, 0: with start).
  task automatic run_pass(input int be_at);
    int p_exp[IN];
    int bad = 0;
    int exp_upd;
    for (int j = 0; j < IN; j++) p_exp[j] = 0;
    for (int i = 0; i < OUT; i++)
      for (int j = 0; j < IN; j++) begin
        p_exp[j]      = sat(longint'(p_exp[j]) + fmul(mw[i * IN + j], me[i]), 16);
        md[i * IN + j] = sat(longint'(md[i * IN + j]) + fmul(ma[j], me[i]), 24);
      end
    start = 1'b1;
    batch_end = (be_at == 0);
    for (int c = 1; c <= N + IN + 1; c++) begin
      tick();
      start     = (c == N + 1);          // must be ignored while busy
      batch_end = (be_at == c);
      wr_en     = (c == 2);              // must be ignored while busy
      wr_sel    = 2'd1; wr_addr = 16'd0; wr_data = 16'h1234;
      if (c <= N) begin
        if (!busy || err_valid || done || update_done) bad++;
      end else if (c <= N + IN) begin
        check("stream_valid", err_valid, 1);
        check("stream_addr", err_addr, c - N - 1);
        check("stream_data", err_data, p_exp[c - N - 1]);
        last_p[c - N - 1] = int'(err_data);
        if (done || !busy) bad++;
      end else begin
        check("done_pulse", done, 1);
        check("done_err_valid", err_valid, 0);
      end
    end
    start = 1'b0; batch_end = 1'b0; wr_en = 1'b0;
    check("mac_phase", bad, 0);
    samples_m = (samples_m >= BATCH) ? BATCH : samples_m + 1;
    exp_upd = (be_at >= 0 || (AUTO != 0 && samples_m == BATCH)) ? 1 : 0;
    tick();
    check("done_single", done, 0);
    wait_update(exp_upd);
  endtask

  task automatic batch_request();
    batch_end = 1'b1;
    tick();
    batch_end = 1'b0;
    check("upd_enter", busy, 1);
    wait_update(1);
  endtask

  initial begin
    int v;
    int bad;
    // Directed load/readback vectors against reset weights -250,-247,-244,-241.
    vecs[0] = '{sel: 1, addr: 1,     data: 100,    rd: 1, exp: 100};
    vecs[1] = '{sel: 3, addr: 2,     data: 555,    rd: 2, exp: -244};
    vecs[2] = '{sel: 1, addr: 4,     data: 7,      rd: 3, exp: -241};
    vecs[3] = '{sel: 1, addr: 3,     data: -5,     rd: 3, exp: -5};
    vecs[4] = '{sel: 0, addr: 0,     data: 9,      rd: 0, exp: -250};
    vecs[5] = '{sel: 1, addr: 65535, data: 1,      rd: 0, exp: -250};
    vecs[6] = '{sel: 1, addr: 0,     data: 32767,  rd: 0, exp: 32767};
    vecs[7] = '{sel: 2, addr: 5,     data: 3,      rd: 2, exp: -244};

    do_reset();
    for (int t = 0; t < 8; t++) begin
      write(vecs[t].sel, vecs[t].addr, vecs[t].data);
      read_w(vecs[t].rd, v);
      check("vec_readback", v, vecs[t].exp);
    end

    // Basic pass and update.
    do_reset();
    for (int k = 0; k < N; k++) write(1, k, 1024);
    write(0, 0, 1024); write(0, 1, 2048);
    write(2, 0, 512);  write(2, 1, 512);
    run_pass(-1);
    check("p0_value", last_p[0], 1024);
    check("p1_value", last_p[1], 1024);
    batch_request();
    read_w(0, v); check("w00_updated", v, 1040);
    read_w(1, v); check("w01_updated", v, 1056);
    read_w(2, v); check("w10_updated", v, 1040);
    read_w(3, v); check("w11_updated", v, 1056);

    // batch_end during MAC: single update right after done.
    run_pass(2);
    check_w_all();

    // Saturation: weights pinned at max, start+batch_end together.
    do_reset();
    for (int k = 0; k < N; k++) write(1, k, 32767);
    for (int j = 0; j < IN; j++) write(0, j, 1024);
    for (int i = 0; i < OUT; i++) write(2, i, 1024);
    run_pass(0);
    read_w(0, v); check("w_sat_high", v, 32767);
    check_w_all();
    for (int k = 0; k < N; k++) write(1, k, -32768);
    for (int j = 0; j < IN; j++) write(0, j, 0);
    for (int i = 0; i < OUT; i++) write(2, i, -32768);
    run_pass(-1);
    check("p_sat_0", last_p[0], 32767);
    check("p_sat_1", last_p[1], 32767);

    // Reset in the third MAC cycle aborts silently and restores weights.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      if (busy || done || update_done || err_valid) bad++;
      tick();
    end
    check("abort_quiet", bad, 0);
    read_w(0, v); check("w0_after_abort", v, -250);
    read_w(1, v); check("w1_after_abort", v, -247);
    read_w(2, v); check("w2_after_abort", v, -244);
    read_w(3, v); check("w3_after_abort", v, -241);

    // Sample counter: two passes with no batch_end.
    do_reset();
    run_pass(-1);
    check("auto_first_pass", last_pulses, 0);
    run_pass(-1);
    check("auto_second_pass", last_pulses, AUTO);

    // Randomized passes against the model.
    for (int it = 0; it < 16; it++) begin
      bit big;
      int r;
      int be;
      big = it[0];
      for (int k = 0; k < N; k++) if ($urandom_range(0, 1) == 1) write(1, k, rnd(big));
      for (int j = 0; j < IN; j++) write(0, j, rnd(big));
      for (int i = 0; i < OUT; i++) write(2, i, rnd(big));
      write(int'($urandom_range(0, 3)), int'($urandom_range(0, 6)), rnd(big));
      r = int'($urandom_range(0, 3));
      be = (r == 0) ? -1 : (r == 1) ? 0 : int'($urandom_range(1, N + IN));
      run_pass(be);
      if (it % 4 == 3) check_w_all();
      if (it % 5 == 4) begin
        batch_request();
        check_w_all();
      end
    end
    check_w_all();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
